// File: rtl/output_drain.sv
// rtl/output_drain.sv - cluster accumulator readout: relu, shift, saturate, stream out via credit-controlled fifo
//
// Walks every (compute unit, output buffer) pair of the cluster, transforms each
// signed accumulator to a saturated OUT_DAT_SIZE result and streams it out.
//
// Ports:
//   clk_i                  clock
//   rst_i                  synchronous active-high reset
//   start_i                drain request, accepted only in IDLE and not while done_o is high
//   relu_en_i, shift_i     transform settings, captured when start_i is accepted
//   out_buf_sel_o          registered buffer select to the cluster
//   com_unit_out_buf_sel_o registered unit select to the cluster
//   out_buf_dat_i          accumulator value, valid RD_LAT cycles after a select change
//   out_dat_o              result at the fifo head (0 while empty)
//   out_valid_o            fifo not empty
//   out_ready_i            downstream ready
//   out_last_o             final element of the drain, qualified by out_valid_o
//   busy_o                 drain in progress, including the done_o cycle
//   done_o                 one-cycle pulse after the last element is accepted
module output_drain #(
  parameter int OUTPUT_BUF_SIZE  = 32,
  parameter int OUTPUT_BUF_NUM   = 32,
  parameter int COMPUTE_UNIT_NUM = 32,
  parameter int OUT_DAT_SIZE     = 8,
  parameter int RD_LAT           = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                relu_en_i,
  input  logic [4:0]                          shift_i,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   out_buf_sel_o,
  output logic [$clog2(COMPUTE_UNIT_NUM)-1:0] com_unit_out_buf_sel_o,
  input  logic [OUTPUT_BUF_SIZE-1:0]          out_buf_dat_i,
  output logic [OUT_DAT_SIZE-1:0]             out_dat_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                out_last_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int BUF_W = $clog2(OUTPUT_BUF_NUM);
  localparam int CU_W  = $clog2(COMPUTE_UNIT_NUM);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(RD_LAT + 2);
  localparam int ENT_W = OUT_DAT_SIZE + 1;

  localparam logic signed [OUTPUT_BUF_SIZE-1:0] SAT_MAX =
    OUTPUT_BUF_SIZE'((2 ** (OUT_DAT_SIZE - 1)) - 1);
  localparam logic signed [OUTPUT_BUF_SIZE-1:0] SAT_MIN =
    OUTPUT_BUF_SIZE'(-(2 ** (OUT_DAT_SIZE - 1)));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   done_q;

  // transform settings latched at start
  logic       relu_q;
  logic [4:0] shift_q;

  // address of the next read to issue
  logic [CU_W-1:0]  cu_q;
  logic [BUF_W-1:0] buf_q;

  // address of the read considered this cycle
  logic [CU_W-1:0]  rd_cu;
  logic [BUF_W-1:0] rd_buf;
  logic             buf_wrap;
  logic             rd_last;

  logic start_acc;
  logic credit_ok;
  logic issue;

  // read tracking: stage 0 is the cycle the selects show the address,
  // stage RD_LAT is the cycle the returning sample is pushed
  logic [RD_LAT:0]  vpipe;
  logic [RD_LAT:0]  lpipe;
  logic [INF_W-1:0] inflight;
  logic             push;
  logic             push_last;

  // transform datapath
  logic signed [OUTPUT_BUF_SIZE-1:0] x_relu;
  logic signed [OUTPUT_BUF_SIZE-1:0] x_shift;
  logic [OUT_DAT_SIZE-1:0]           sat_dat;

  // output fifo
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;
  logic             pop;
  logic             flush_done;
  logic [7:0]       committed;

  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];
  assign pop        = !fifo_empty && out_ready_i;
  assign push       = vpipe[RD_LAT];
  assign push_last  = lpipe[RD_LAT];
  assign flush_done = (state_q == S_FLUSH) && pop && head[ENT_W-1];

  // The start edge itself issues read (0,0), so counters are taken as zero in IDLE.
  assign rd_cu    = (state_q == S_IDLE) ? '0 : cu_q;
  assign rd_buf   = (state_q == S_IDLE) ? '0 : buf_q;
  assign buf_wrap = (rd_buf == BUF_W'(OUTPUT_BUF_NUM - 1));
  assign rd_last  = buf_wrap && (rd_cu == CU_W'(COMPUTE_UNIT_NUM - 1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight = inflight + INF_W'(vpipe[i]);
    end
  end

  // Slots committed after this edge: fifo contents minus this cycle's pop plus
  // every read still in flight. Counting the pop lets a full fifo keep
  // streaming at one element per cycle.
  assign committed = 8'(fifo_count) + 8'(inflight) - 8'(pop);
  assign credit_ok = (committed < 8'(FIFO_DEPTH));

  assign start_acc = (state_q == S_IDLE) && start_i && !done_q && credit_ok;
  assign issue     = start_acc || ((state_q == S_ISSUE) && credit_ok);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= flush_done;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = rd_last ? S_FLUSH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue && rd_last) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o      = (state_q != S_IDLE) || done_q;
    done_o      = done_q;
    out_valid_o = !fifo_empty;
    out_dat_o   = fifo_empty ? '0 : head[OUT_DAT_SIZE-1:0];
    out_last_o  = !fifo_empty && head[ENT_W-1];
  end

  // ---------------------------------------------------------------------------
  // Transform: relu, arithmetic shift, saturate
  // ---------------------------------------------------------------------------
  always_comb begin
    x_relu  = (relu_q && out_buf_dat_i[OUTPUT_BUF_SIZE-1]) ? '0 : $signed(out_buf_dat_i);
    x_shift = x_relu >>> shift_q;
    if (x_shift > SAT_MAX) begin
      sat_dat = SAT_MAX[OUT_DAT_SIZE-1:0];
    end else if (x_shift < SAT_MIN) begin
      sat_dat = SAT_MIN[OUT_DAT_SIZE-1:0];
    end else begin
      sat_dat = x_shift[OUT_DAT_SIZE-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Issue counters, selects and read tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      relu_q                 <= 1'b0;
      shift_q                <= '0;
      cu_q                   <= '0;
      buf_q                  <= '0;
      out_buf_sel_o          <= '0;
      com_unit_out_buf_sel_o <= '0;
      vpipe                  <= '0;
      lpipe                  <= '0;
    end else begin
      if (start_acc) begin
        relu_q  <= relu_en_i;
        shift_q <= shift_i;
      end
      if (issue) begin
        out_buf_sel_o          <= rd_buf;
        com_unit_out_buf_sel_o <= rd_cu;
        if (buf_wrap) begin
          buf_q <= '0;
          cu_q  <= rd_cu + CU_W'(1);
        end else begin
          buf_q <= rd_buf + BUF_W'(1);
          cu_q  <= rd_cu;
        end
      end
      vpipe[0] <= issue;
      lpipe[0] <= issue && rd_last;
      for (int i = 1; i <= RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output fifo
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: the head is masked while the fifo is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {push_last, sat_dat};
    end
  end

endmodule
